// File: rtl/serial_io_bus_decoder_pkg.sv
// Shared types and constants for the serial IO bus decoder.
// Optional unmapped-access error path: SERIAL_IO_UNMAPPED_ERR_EN.
package serial_io_pkg;

    localparam int          CNT_W            = 4;
    localparam int          UART_BLOCK_BYTES = 16;
    localparam logic [15:0] IO_WINDOW        = 16'hFF21;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
        , ERR
`endif
    } state_e;

    // A phase of N cycles loads N-1 so the timer reaches zero on its last cycle.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/serial_io_bus_decoder_if.sv
// Bridge-side request signals and UART-side enables/strobes of the decoder.
// Error_H exists only when SERIAL_IO_UNMAPPED_ERR_EN is defined.
interface serial_io_bus_decoder_if #(
    parameter int NUM_CHANNELS = 3
);
    // Handshake: a request is presented while IOSelect_H and exactly one of
    // Read_H/Write_H are high; WaitRequest_H high means the request is held
    // off, and the access is complete in the single cycle Ack_H is high.
    logic [15:0]             Address;
    logic                    IOSelect_H;
    logic                    ByteSelect_L;
    logic                    Read_H;
    logic                    Write_H;
    logic [NUM_CHANNELS-1:0] Port_Enable;
    logic                    Port_Read_L;
    logic                    Port_Write_L;
    logic                    WaitRequest_H;
    logic                    Ack_H;
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
    logic                    Error_H;
`endif

    modport master (
        output Address, IOSelect_H, ByteSelect_L, Read_H, Write_H,
        input  Port_Enable, Port_Read_L, Port_Write_L, WaitRequest_H, Ack_H
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
        , input Error_H
`endif
    );

    modport slave (
        input  Address, IOSelect_H, ByteSelect_L, Read_H, Write_H,
        output Port_Enable, Port_Read_L, Port_Write_L, WaitRequest_H, Ack_H
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
        , output Error_H
`endif
    );

endinterface

// File: rtl/serial_io_bus_decoder_phase_timer.sv
// Loadable down-counter timing the SETUP, STROBE and HOLD phases.
module serial_io_phase_timer
    import serial_io_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/serial_io_bus_decoder.sv
// Decodes the IO window into per-UART chip enables with timed read/write strobes.
// Define SERIAL_IO_UNMAPPED_ERR_EN to answer unmapped requests with Error_H+Ack_H.
module serial_io_bus_decoder
    import serial_io_pkg::*;
#(
    parameter int          NUM_CHANNELS  = 3,
    parameter logic [11:0] BASE_BLOCK    = 12'h020,
    parameter int          SETUP_CYCLES  = 1,
    parameter int          STROBE_CYCLES = 2,
    parameter int          HOLD_CYCLES   = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_L,
    serial_io_bus_decoder_if.slave  bus,
    output state_e                  dbg_state_o
);

    localparam int               CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYCLES);

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic                    wr_q, wr_d;
    logic [NUM_CHANNELS-1:0] en_q, en_d;
    logic                    rd_l_q, wr_l_q;
    logic                    load;
    logic [CNT_W-1:0]        load_val;
    logic                    phase_done;
    logic                    wait_req;
    logic [11:0]             blk_idx;
    logic                    req_valid, hit;
    logic                    unused_addr_lo;

    // Below-base blocks wrap to large unsigned indices and fall out of range.
    assign blk_idx        = bus.Address[15:4] - BASE_BLOCK;
    assign unused_addr_lo = ^bus.Address[3:0];
    assign req_valid      = bus.IOSelect_H & (bus.Read_H ^ bus.Write_H);
    assign hit            = req_valid & ~bus.ByteSelect_L & (blk_idx < 12'(NUM_CHANNELS));

`ifdef SERIAL_IO_UNMAPPED_ERR_EN
    logic err_q, err_d;
`endif

    serial_io_phase_timer u_timer (
        .Clk      (Clk),
        .Reset_L  (Reset_L),
        .load     (load),
        .load_val (load_val),
        .done     (phase_done)
    );

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        wr_d     = wr_q;
        load     = 1'b0;
        load_val = '0;
        wait_req = 1'b0;
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit) begin
                    chan_d   = blk_idx[CH_W-1:0];
                    wr_d     = bus.Write_H;
                    wait_req = 1'b1;
                    load     = 1'b1;
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
                    err_d    = 1'b0;
`endif
                    if (SETUP_CYCLES > 0) begin
                        state_d  = SETUP;
                        load_val = SETUP_LD;
                    end else begin
                        state_d  = STROBE;
                        load_val = STROBE_LD;
                    end
                end
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
                else if (req_valid) begin
                    wait_req = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ERR;
                end
`endif
            end
            SETUP: begin
                wait_req = 1'b1;
                if (phase_done) begin
                    state_d  = STROBE;
                    load     = 1'b1;
                    load_val = STROBE_LD;
                end
            end
            STROBE: begin
                wait_req = 1'b1;
                if (phase_done) begin
                    if (HOLD_CYCLES > 0) begin
                        state_d  = HOLD;
                        load     = 1'b1;
                        load_val = HOLD_LD;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            HOLD: begin
                wait_req = 1'b1;
                if (phase_done) state_d = DONE;
            end
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
            ERR: begin
                wait_req = 1'b1;
                state_d  = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Enables and strobes are registered from the next state so they leave the flops clean.
    always_comb begin
        en_d = '0;
        if (state_d == SETUP || state_d == STROBE || state_d == HOLD) begin
            en_d = NUM_CHANNELS'(1) << chan_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            chan_q  <= '0;
            wr_q    <= 1'b0;
            en_q    <= '0;
            rd_l_q  <= 1'b1;
            wr_l_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            wr_q    <= wr_d;
            en_q    <= en_d;
            rd_l_q  <= !(state_d == STROBE && !wr_d);
            wr_l_q  <= !(state_d == STROBE && wr_d);
        end
    end

`ifdef SERIAL_IO_UNMAPPED_ERR_EN
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign bus.Error_H = (state_q == DONE) && err_q;
`endif

    assign bus.Port_Enable   = en_q;
    assign bus.Port_Read_L   = rd_l_q;
    assign bus.Port_Write_L  = wr_l_q;
    assign bus.WaitRequest_H = wait_req;
    assign bus.Ack_H         = (state_q == DONE);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_serial_io_bus_decoder.sv
// Scoreboarded bench: per-access cycle maps of enable/strobe/wait are compared
// against hand-computed expectations for a default and a wide zero-setup instance.
module tb_serial_io_bus_decoder;
    import serial_io_pkg::*;

    localparam int W = 82;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_io_bus_decoder_if #(.NUM_CHANNELS(3)) bus_a ();
    serial_io_bus_decoder_if #(.NUM_CHANNELS(8)) bus_b ();
    state_e dbg_a, dbg_b;
    logic   err_a, err_b;

    serial_io_bus_decoder u_dut_a (
        .Clk         (clk),
        .Reset_L     (rst_n),
        .bus         (bus_a.slave),
        .dbg_state_o (dbg_a)
    );

    serial_io_bus_decoder #(
        .NUM_CHANNELS (8),
        .BASE_BLOCK   (12'h0F8),
        .SETUP_CYCLES (0),
        .HOLD_CYCLES  (0)
    ) u_dut_b (
        .Clk         (clk),
        .Reset_L     (rst_n),
        .bus         (bus_b.slave),
        .dbg_state_o (dbg_b)
    );

`ifdef SERIAL_IO_UNMAPPED_ERR_EN
    assign err_a = bus_a.Error_H;
    assign err_b = bus_b.Error_H;
`else
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Record: dut, error, enable mask, per-cycle enable/read/write/wait maps, ack cycle, idle gap.
    function automatic logic [W-1:0] rec(input logic d, input logic err, input logic [7:0] mask,
                                         input logic [15:0] en, input logic [15:0] rd,
                                         input logic [15:0] wr, input logic [15:0] wt,
                                         input logic [3:0] ack, input logic [3:0] gap);
        return {d, err, mask, en, rd, wr, wt, ack, gap};
    endfunction

    function automatic logic [W-1:0] e_wr(input logic [7:0] mask, input logic [3:0] gap);
        return rec(1'b0, 1'b0, mask, 16'h001E, 16'h0000, 16'h000C, 16'h001F, 4'd5, gap);
    endfunction

    function automatic logic [W-1:0] e_rd(input logic [7:0] mask);
        return rec(1'b0, 1'b0, mask, 16'h001E, 16'h000C, 16'h0000, 16'h001F, 4'd5, 4'd15);
    endfunction

    // ---------------- monitor ----------------
    logic        active[2];
    logic        err_seen[2];
    int          cyc[2];
    logic [7:0]  mask[2];
    logic [15:0] en_b[2], rd_b[2], wr_b[2], wt_b[2];
    logic [3:0]  gap[2], sgap[2];

    task automatic mon_step(input int d, input logic [7:0] en, input logic rd_l, input logic wr_l,
                            input logic wt, input logic ack, input logic err);
        logic [W-1:0] act;
        if (!rst_n) begin
            active[d] = 1'b0;
            gap[d]    = 4'd15;
            return;
        end
        check("onehot", W'($countones(en) <= 1), W'(1));
        if (!active[d] && wt) begin
            active[d] = 1'b1;
            cyc[d]    = 0;
            mask[d]   = '0;
            en_b[d]   = '0;
            rd_b[d]   = '0;
            wr_b[d]   = '0;
            wt_b[d]   = '0;
            err_seen[d] = 1'b0;
            sgap[d]   = gap[d];
        end
        if (active[d]) begin
            mask[d]        = mask[d] | en;
            en_b[d][cyc[d]] = |en;
            rd_b[d][cyc[d]] = !rd_l;
            wr_b[d][cyc[d]] = !wr_l;
            wt_b[d][cyc[d]] = wt;
            err_seen[d]    = err_seen[d] | err;
            if (ack) begin
                act = rec(d == 1, err_seen[d], mask[d], en_b[d], rd_b[d], wr_b[d], wt_b[d],
                          4'(cyc[d]), sgap[d]);
                if (exp_q.size() == 0) check("unexpected_ack", act, '0);
                else check("access", act, exp_q.pop_front());
                active[d] = 1'b0;
                gap[d]    = 4'd0;
            end else if (cyc[d] == 15) begin
                check("ack_timeout", W'(1), W'(0));
                active[d] = 1'b0;
            end
            cyc[d]++;
        end else begin
            check("quiet", {en != 0, !rd_l, !wr_l, ack}, '0);
            if (gap[d] != 4'd15) gap[d]++;
        end
    endtask

    always @(negedge clk)
        mon_step(0, {5'b0, bus_a.Port_Enable}, bus_a.Port_Read_L, bus_a.Port_Write_L,
                 bus_a.WaitRequest_H, bus_a.Ack_H, err_a);
    always @(negedge clk)
        mon_step(1, bus_b.Port_Enable, bus_b.Port_Read_L, bus_b.Port_Write_L,
                 bus_b.WaitRequest_H, bus_b.Ack_H, err_b);

    // ---------------- drivers ----------------
    task automatic drive_a(input logic [15:0] addr, input logic iosel, input logic bsel,
                           input logic rd, input logic wr);
        @(posedge clk);
        #1;
        bus_a.Address      = addr;
        bus_a.IOSelect_H   = iosel;
        bus_a.ByteSelect_L = bsel;
        bus_a.Read_H       = rd;
        bus_a.Write_H      = wr;
    endtask

    task automatic idle_a();
        @(posedge clk);
        #1;
        bus_a.Address      = '0;
        bus_a.IOSelect_H   = 1'b0;
        bus_a.ByteSelect_L = 1'b1;
        bus_a.Read_H       = 1'b0;
        bus_a.Write_H      = 1'b0;
    endtask

    task automatic one_shot_a(input logic [15:0] addr, input logic iosel, input logic bsel,
                              input logic rd, input logic wr);
        drive_a(addr, iosel, bsel, rd, wr);
        idle_a();
        repeat (20) @(posedge clk);
    endtask

    task automatic miss_a(input logic [15:0] addr, input logic bsel, input logic rd, input logic wr);
`ifdef SERIAL_IO_UNMAPPED_ERR_EN
        if (rd ^ wr)
            exp_q.push_back(rec(1'b0, 1'b1, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0003, 4'd2, 4'd15));
`endif
        one_shot_a(addr, 1'b1, bsel, rd, wr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   W'(bus_a.Port_Enable),   '0);
        check({tag, "_rd"},   W'(bus_a.Port_Read_L),   W'(1));
        check({tag, "_wr"},   W'(bus_a.Port_Write_L),  W'(1));
        check({tag, "_wait"}, W'(bus_a.WaitRequest_H), '0);
        check({tag, "_ack"},  W'(bus_a.Ack_H),         '0);
        check({tag, "_fsm"},  W'(dbg_a),               W'(IDLE));
    endtask

    initial begin
        bus_a.Address = '0; bus_a.IOSelect_H = 1'b0; bus_a.ByteSelect_L = 1'b1;
        bus_a.Read_H  = 1'b0; bus_a.Write_H = 1'b0;
        bus_b.Address = '0; bus_b.IOSelect_H = 1'b0; bus_b.ByteSelect_L = 1'b1;
        bus_b.Read_H  = 1'b0; bus_b.Write_H = 1'b0;

        #12;
        check_reset_outputs("reset");
        check("reset_b_en", W'(bus_b.Port_Enable), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Writes and reads to each channel of the default instance
        exp_q.push_back(e_wr(8'h02, 4'd15));
        one_shot_a(16'h0210, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(e_rd(8'h01));
        one_shot_a(16'h0200, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(e_rd(8'h04));
        one_shot_a(16'h022E, 1'b1, 1'b0, 1'b1, 1'b0);

        // Requests that must not hit
        miss_a(16'h0230, 1'b0, 1'b1, 1'b0);
        miss_a(16'h01F0, 1'b0, 1'b1, 1'b0);
        miss_a(16'h0210, 1'b1, 1'b1, 1'b0);
        miss_a(16'h0210, 1'b0, 1'b1, 1'b1);
        one_shot_a(16'h0210, 1'b0, 1'b0, 1'b1, 1'b0);

        // Wide instance, zero setup/hold, top channel
        exp_q.push_back(rec(1'b1, 1'b0, 8'h80, 16'h0006, 16'h0006, 16'h0000, 16'h0007, 4'd3, 4'd15));
        @(posedge clk);
        #1;
        bus_b.Address = 16'h0FF0; bus_b.IOSelect_H = 1'b1; bus_b.ByteSelect_L = 1'b0;
        bus_b.Read_H  = 1'b1;
        @(posedge clk);
        #1;
        bus_b.IOSelect_H = 1'b0; bus_b.Read_H = 1'b0; bus_b.ByteSelect_L = 1'b1;
        repeat (20) @(posedge clk);

        // Reset asserted during STROBE aborts the access
        drive_a(16'h0210, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_a();
        @(posedge clk);
        #1;
        check("strobe_before_reset", W'(bus_a.Port_Write_L), '0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        exp_q.push_back(e_wr(8'h04, 4'd15));
        one_shot_a(16'h0220, 1'b1, 1'b0, 1'b0, 1'b1);

        // Request held across two accesses; address moves mid-access
        exp_q.push_back(e_wr(8'h02, 4'd15));
        exp_q.push_back(e_wr(8'h04, 4'd0));
        drive_a(16'h0210, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 bus_a.Address = 16'h0220;
        repeat (5) @(posedge clk);
        #1;
        bus_a.IOSelect_H = 1'b0; bus_a.Write_H = 1'b0; bus_a.ByteSelect_L = 1'b1;
        repeat (20) @(posedge clk);

        check("queue_drained", W'(exp_q.size()), '0);
        check("no_open_access", W'({active[0], active[1]}), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
